// File: rtl/map_pkg.sv
// Shared map geometry, tile codes, scheduler states and the border test.
package map_pkg;

    localparam int unsigned MAP_W  = 20;
    localparam int unsigned MAP_H  = 15;
    localparam int unsigned CELLS  = MAP_W * MAP_H;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned TILE_W = 3;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned COL_W  = 5;

    localparam logic [TILE_W-1:0] TILE_EMPTY = 3'd0;
    localparam logic [TILE_W-1:0] TILE_WALL  = 3'd1;
    localparam logic [TILE_W-1:0] TILE_BRICK = 3'd2;
    localparam logic [TILE_W-1:0] TILE_BASE2 = 3'd3;
    localparam logic [TILE_W-1:0] TILE_BASE1 = 3'd4;

    typedef enum logic [1:0] {INIT, RUN, CLEAR, HALT} sched_state_t;

    // Border cell test on a flat cell index; constant-multiplied row starts, no divider.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic b;
        b = 1'b0;
        if (addr < ADDR_W'(MAP_W)) b = 1'b1;
        if ((addr >= ADDR_W'(CELLS - MAP_W)) && (addr < ADDR_W'(CELLS))) b = 1'b1;
        for (int unsigned r = 0; r < MAP_H; r++) begin
            if ((addr == ADDR_W'(r * MAP_W)) || (addr == ADDR_W'(r * MAP_W + MAP_W - 1)))
                b = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/map_rr_arbiter.sv
// 2-way round-robin arbiter with same-address merge.
//  en        arbitration allowed this cycle
//  v1/a1     player 1 request valid / cell index
//  v2/a2     player 2 request valid / cell index
//  ptr       0 favours player 1, 1 favours player 2
//  grant1/2  combinational grants (both high on a same-address merge)
//  ptr_next  pointer value to register
module map_rr_arbiter
    import map_pkg::*;
(
    input  logic              en,
    input  logic              v1,
    input  logic [ADDR_W-1:0] a1,
    input  logic              v2,
    input  logic [ADDR_W-1:0] a2,
    input  logic              ptr,
    output logic              grant1,
    output logic              grant2,
    output logic              ptr_next
);

    always_comb begin
        grant1   = 1'b0;
        grant2   = 1'b0;
        ptr_next = ptr;
        if (en) begin
            if (v1 && v2) begin
                if (a1 == a2) begin
                    // Same cell: one write serves both, fairness state untouched.
                    grant1 = 1'b1;
                    grant2 = 1'b1;
                end else begin
                    grant1   = ~ptr;
                    grant2   = ptr;
                    ptr_next = ~ptr;
                end
            end else if (v1) begin
                grant1 = 1'b1;
            end else if (v2) begin
                grant2 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/map_update_scheduler.sv
// Sole writer of the 20x15 tile map: ROM copy after reset, player tile clears
// during play, end-screen sweep on a win, then halt.
//  Clk, Reset           clock, async active-high reset
//  req1_*/req2_*        player clear requests (valid/addr in, ready out, combinational)
//  win                  level-sensitive win indication
//  rom_addr/rom_data    level ROM read port (data 1 cycle after address)
//  map_we/waddr/wdata   registered map RAM write port
//  init_busy            high while copying the ROM
//  game_over            high while sweeping and halted
module map_update_scheduler
    import map_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    input  logic              req2_valid,
    input  logic [ADDR_W-1:0] req2_addr,
    output logic              req2_ready,
    input  logic              win,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TILE_W-1:0] rom_data,
    output logic              map_we,
    output logic [ADDR_W-1:0] map_waddr,
    output logic [TILE_W-1:0] map_wdata,
    output logic              init_busy,
    output logic              game_over
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    sched_state_t      state;
    logic              issue_done;
    logic              rd_vld;
    logic [ADDR_W-1:0] rd_addr;
    logic              win_pending;
    logic              rr_ptr;
    logic              rr_ptr_next;
    logic [ADDR_W-1:0] clr_addr;
    logic [ROW_W-1:0]  clr_row;
    logic [COL_W-1:0]  clr_col;
    logic              grant1;
    logic              grant2;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_drop;
    logic              clr_border;
    logic              last_write;

    map_rr_arbiter u_arb (
        .en       ((state == RUN) && !win),
        .v1       (req1_valid),
        .a1       (req1_addr),
        .v2       (req2_valid),
        .a2       (req2_addr),
        .ptr      (rr_ptr),
        .grant1   (grant1),
        .grant2   (grant2),
        .ptr_next (rr_ptr_next)
    );

    assign req1_ready = grant1;
    assign req2_ready = grant2;

    // On a merge both addresses are equal, so player 1's address is correct either way.
    assign gnt_addr   = grant1 ? req1_addr : req2_addr;
    assign gnt_drop   = (gnt_addr >= ADDR_W'(CELLS)) || is_border(gnt_addr);
    assign clr_border = (clr_row == '0) || (clr_row == ROW_W'(MAP_H - 1)) ||
                        (clr_col == '0) || (clr_col == COL_W'(MAP_W - 1));
    // The final cell of a sweep is currently visible on the write port.
    assign last_write = map_we && (map_waddr == LAST_ADDR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= INIT;
            rom_addr    <= '0;
            issue_done  <= 1'b0;
            rd_vld      <= 1'b0;
            rd_addr     <= '0;
            win_pending <= 1'b0;
            rr_ptr      <= 1'b0;
            clr_addr    <= '0;
            clr_row     <= '0;
            clr_col     <= '0;
            map_we      <= 1'b0;
            map_waddr   <= '0;
            map_wdata   <= '0;
            init_busy   <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            map_we <= 1'b0;
            rd_vld <= 1'b0;
            case (state)
                INIT: begin
                    if (win) win_pending <= 1'b1;
                    // Stage 1: issue ROM reads 0..299, address holds at the end.
                    if (!issue_done) begin
                        rd_vld  <= 1'b1;
                        rd_addr <= rom_addr;
                        if (rom_addr == LAST_ADDR) issue_done <= 1'b1;
                        else                       rom_addr   <= rom_addr + ADDR_W'(1);
                    end
                    // Stage 2: ROM data is now valid for rd_addr.
                    if (rd_vld) begin
                        map_we    <= 1'b1;
                        map_waddr <= rd_addr;
                        map_wdata <= rom_data;
                    end
                    if (last_write) begin
                        init_busy <= 1'b0;
                        if (win_pending || win) begin
                            state     <= CLEAR;
                            game_over <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (win) begin
                        state     <= CLEAR;
                        game_over <= 1'b1;
                    end else begin
                        if ((grant1 || grant2) && !gnt_drop) begin
                            map_we    <= 1'b1;
                            map_waddr <= gnt_addr;
                            map_wdata <= TILE_EMPTY;
                        end
                        rr_ptr <= rr_ptr_next;
                    end
                end
                CLEAR: begin
                    if (last_write) begin
                        state <= HALT;
                    end else begin
                        map_we    <= 1'b1;
                        map_waddr <= clr_addr;
                        map_wdata <= clr_border ? TILE_WALL : TILE_EMPTY;
                        clr_addr  <= clr_addr + ADDR_W'(1);
                        if (clr_col == COL_W'(MAP_W - 1)) begin
                            clr_col <= '0;
                            clr_row <= clr_row + ROW_W'(1);
                        end else begin
                            clr_col <= clr_col + COL_W'(1);
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_map_update_scheduler.sv
// Directed bench for map_update_scheduler: ROM copy, arbitration, drops, win sweep, reset.
module tb_map_update_scheduler;

    logic       Clk;
    logic       Reset;
    logic       req1_valid;
    logic [8:0] req1_addr;
    logic       req1_ready;
    logic       req2_valid;
    logic [8:0] req2_addr;
    logic       req2_ready;
    logic       win;
    logic [8:0] rom_addr;
    logic [2:0] rom_data;
    logic       map_we;
    logic [8:0] map_waddr;
    logic [2:0] map_wdata;
    logic       init_busy;
    logic       game_over;

    int passed = 0;
    int total  = 0;

    map_update_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .req2_valid (req2_valid),
        .req2_addr  (req2_addr),
        .req2_ready (req2_ready),
        .win        (win),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .map_we     (map_we),
        .map_waddr  (map_waddr),
        .map_wdata  (map_wdata),
        .init_busy  (init_busy),
        .game_over  (game_over)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic bit border_of(input int a);
        int r;
        int c;
        r = a / 20;
        c = a % 20;
        return (r == 0) || (r == 14) || (c == 0) || (c == 19);
    endfunction

    // Level ROM contents: walls on the border, a mix of tile codes inside.
    function automatic logic [2:0] rom_fn(input int a);
        if (border_of(a)) return 3'd1;
        return 3'((a * 7 + a / 20) % 5);
    endfunction

    function automatic logic [2:0] clear_fn(input int a);
        return border_of(a) ? 3'd1 : 3'd0;
    endfunction

    // Synchronous ROM model: data one cycle after address.
    always @(posedge Clk) rom_data <= rom_fn(int'(rom_addr));

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Runs the ROM copy from reset release; optional one-cycle win pulse at cycle win_at.
    task automatic run_init(input int win_at, output int nwr, output int errs,
                            output int first_wr, output int w299, output int ib_fall);
        nwr = 0; errs = 0; first_wr = -1; w299 = -1; ib_fall = -1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge Clk);
            if (map_we) begin
                if (first_wr < 0) first_wr = cyc;
                if (int'(map_waddr) != nwr || map_wdata != rom_fn(nwr)) errs++;
                if (map_waddr == 9'd299) w299 = cyc;
                nwr++;
            end
            if (!init_busy) begin
                ib_fall = cyc;
                break;
            end
            if (cyc == win_at) win = 1'b1;
            else win = 1'b0;
        end
    endtask

    int nwr, errs, first_wr, w299, ib_fall;
    int ncl, cerrs, wd20, wd21, wd299, halt_wr;
    int found150, rst_wr;
    int drop_addr [4] = '{0, 19, 310, 40};

    initial begin
        Reset = 1'b1; win = 1'b0;
        req1_valid = 1'b1; req1_addr = 9'd21;
        req2_valid = 1'b0; req2_addr = 9'd0;
        repeat (3) @(negedge Clk);
        check("rst_rom_addr",  rom_addr,   0);
        check("rst_map_we",    map_we,     0);
        check("rst_waddr",     map_waddr,  0);
        check("rst_wdata",     map_wdata,  0);
        check("rst_ready1",    req1_ready, 0);
        check("rst_init_busy", init_busy,  1);
        check("rst_game_over", game_over,  0);
        req1_valid = 1'b0;

        // ROM copy
        Reset = 1'b0;
        run_init(-1, nwr, errs, first_wr, w299, ib_fall);
        check("init_writes",    nwr,            300);
        check("init_seq_errs",  errs,           0);
        check("init_first_wr",  first_wr,       2);
        check("init_busy_fall", ib_fall - w299, 1);
        check("init_rom_hold",  rom_addr,       299);
        check("init_game_over", game_over,      0);

        // Single requester
        req1_valid = 1'b1; req1_addr = 9'd21;
        #1;
        check("t2_ready1", req1_ready, 1);
        check("t2_ready2", req2_ready, 0);
        @(negedge Clk);
        req1_valid = 1'b0;
        check("t2_we",    map_we,    1);
        check("t2_waddr", map_waddr, 21);
        check("t2_wdata", map_wdata, 0);

        // Both valid, different cells: p1 first, then p2
        req1_valid = 1'b1; req1_addr = 9'd28;
        req2_valid = 1'b1; req2_addr = 9'd268;
        #1;
        check("t3_ready1_first", req1_ready, 1);
        check("t3_ready2_first", req2_ready, 0);
        @(negedge Clk);
        check("t3_waddr_28", map_waddr, 28);
        check("t3_we_28",    map_we,    1);
        req1_valid = 1'b0;
        #1;
        check("t3_ready2_second", req2_ready, 1);
        @(negedge Clk);
        req2_valid = 1'b0;
        check("t3_waddr_268", map_waddr, 268);
        check("t3_we_268",    map_we,    1);

        // Pointer now favours player 2
        req1_valid = 1'b1; req1_addr = 9'd22;
        req2_valid = 1'b1; req2_addr = 9'd23;
        #1;
        check("rr_ready2_first", req2_ready, 1);
        check("rr_ready1_wait",  req1_ready, 0);
        @(negedge Clk);
        req2_valid = 1'b0;
        check("rr_waddr_23", map_waddr, 23);
        #1;
        check("rr_ready1_second", req1_ready, 1);
        @(negedge Clk);
        req1_valid = 1'b0;
        check("rr_waddr_22", map_waddr, 22);

        // Same address merge
        req1_valid = 1'b1; req1_addr = 9'd30;
        req2_valid = 1'b1; req2_addr = 9'd30;
        #1;
        check("t4_ready1", req1_ready, 1);
        check("t4_ready2", req2_ready, 1);
        @(negedge Clk);
        req1_valid = 1'b0; req2_valid = 1'b0;
        check("t4_we",    map_we,    1);
        check("t4_waddr", map_waddr, 30);
        @(negedge Clk);
        check("t4_single_write", map_we, 0);

        // Dropped requests: consumed, never written
        foreach (drop_addr[i]) begin
            req1_valid = 1'b1; req1_addr = 9'(drop_addr[i]);
            #1;
            check($sformatf("drop_ready_%0d", drop_addr[i]), req1_ready, 1);
            @(negedge Clk);
            req1_valid = 1'b0;
            check($sformatf("drop_we_%0d", drop_addr[i]), map_we, 0);
        end

        // win in RUN blocks the grant and moves to the sweep
        win = 1'b1; req1_valid = 1'b1; req1_addr = 9'd50;
        #1;
        check("win_run_ready", req1_ready, 0);
        @(negedge Clk);
        req1_valid = 1'b0;
        check("win_run_game_over", game_over, 1);
        check("win_run_we",        map_we,    0);
        win = 1'b0;

        // Win pulsed during INIT
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        run_init(50, nwr, errs, first_wr, w299, ib_fall);
        win = 1'b0;
        check("t5_init_writes",   nwr,       300);
        check("t5_init_errs",     errs,      0);
        check("t5_game_over_ent", game_over, 1);
        ncl = 0; cerrs = 0; wd20 = -1; wd21 = -1; wd299 = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge Clk);
            if (map_we) begin
                if (int'(map_waddr) != ncl || map_wdata != clear_fn(ncl)) cerrs++;
                if (map_waddr == 9'd20)  wd20  = int'(map_wdata);
                if (map_waddr == 9'd21)  wd21  = int'(map_wdata);
                if (map_waddr == 9'd299) wd299 = int'(map_wdata);
                ncl++;
            end else if (ncl == 300) begin
                break;
            end
        end
        check("t5_clear_writes", ncl,   300);
        check("t5_clear_errs",   cerrs, 0);
        check("t5_cell20",       wd20,  1);
        check("t5_cell21",       wd21,  0);
        check("t5_cell299",      wd299, 1);
        req1_valid = 1'b1; req1_addr = 9'd21;
        halt_wr = 0;
        repeat (10) begin
            @(negedge Clk);
            if (map_we || req1_ready) halt_wr++;
        end
        req1_valid = 1'b0;
        check("t5_halt_quiet",     halt_wr,   0);
        check("t5_halt_game_over", game_over, 1);
        check("t5_halt_init_busy", init_busy, 0);

        // Reset in the middle of the sweep
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        run_init(-1, nwr, errs, first_wr, w299, ib_fall);
        win = 1'b1;
        found150 = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge Clk);
            if (map_we && game_over && map_waddr == 9'd150) begin
                found150 = 1;
                break;
            end
        end
        check("t6_reached_150", found150, 1);
        Reset = 1'b1;
        #1;
        check("t6_rst_we",        map_we,    0);
        check("t6_rst_waddr",     map_waddr, 0);
        check("t6_rst_rom_addr",  rom_addr,  0);
        check("t6_rst_init_busy", init_busy, 1);
        check("t6_rst_game_over", game_over, 0);
        win = 1'b0;
        rst_wr = 0;
        repeat (2) begin
            @(negedge Clk);
            if (map_we) rst_wr++;
        end
        check("t6_no_write_in_reset", rst_wr, 0);
        Reset = 1'b0;
        #1;
        check("t6_restart_addr0", rom_addr, 0);
        @(negedge Clk);
        check("t6_restart_addr1", rom_addr, 1);
        @(negedge Clk);
        check("t6_restart_we",    map_we,    1);
        check("t6_restart_waddr", map_waddr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
